// File: rtl/sram_ctrl.sv
// Synchronous initiator for the asynchronous sram model: sequences registered N_WE/N_OE
// strobes for one host request at a time and returns read data.
module sram_ctrl #(
  parameter int DEPTH     = 12,
  parameter int WIDTH     = 8,
  parameter int WE_CYCLES = 1,
  parameter int RD_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [DEPTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic [DEPTH-1:0] sram_addr_o,
  output logic [WIDTH-1:0] sram_wdata_o,
  input  logic [WIDTH-1:0] sram_rdata_i,
  output logic             sram_n_we_o,
  output logic             sram_n_oe_o
);

  localparam int CNT_MAX = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] WE_LOAD = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);

  if (WE_CYCLES < 1 || RD_CYCLES < 1) begin : g_param_check
    $error("sram_ctrl: WE_CYCLES and RD_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, READ, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             n_we_q, n_we_d;
  logic             n_oe_q, n_oe_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      n_we_q      <= 1'b1;
      n_oe_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      n_we_q      <= n_we_d;
      n_oe_q      <= n_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    // Completion pulse is registered off HOLD/DONE, landing one cycle after those states.
    rsp_valid_d = (state_q == HOLD) || (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (req_we_i) begin
            state_d = SETUP;
          end else begin
            state_d = READ;
            cnt_d   = RD_LOAD;
          end
        end
      end
      SETUP: begin
        state_d = WRITE;
        cnt_d   = WE_LOAD;
      end
      WRITE: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      HOLD: state_d = IDLE;
      READ: begin
        if (cnt_q == '0) begin
          rdata_d = sram_rdata_i;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes are decoded from the next state so they leave flops aligned with the state.
    n_we_d = (state_d != WRITE);
    n_oe_d = (state_d != READ);
  end

  assign req_ready_o  = (state_q == IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rdata_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign sram_n_we_o  = n_we_q;
  assign sram_n_oe_o  = n_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: two instances (default timing and WE=3/RD=2), each wired
// to a behavioural sram that captures on the N_WE fall and drives data while N_OE is low.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_we;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        a_valid, b_valid;

  logic        a_ready, a_rsp_valid, a_n_we, a_n_oe;
  logic [7:0]  a_rsp_rdata, a_wdata, a_rdata;
  logic [11:0] a_addr;
  logic        b_ready, b_rsp_valid, b_n_we, b_n_oe;
  logic [7:0]  b_rsp_rdata, b_wdata, b_rdata;
  logic [11:0] b_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(a_valid), .req_ready_o(a_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata),
    .sram_addr_o(a_addr), .sram_wdata_o(a_wdata), .sram_rdata_i(a_rdata),
    .sram_n_we_o(a_n_we), .sram_n_oe_o(a_n_oe)
  );

  sram_ctrl #(.WE_CYCLES(3), .RD_CYCLES(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata),
    .sram_addr_o(b_addr), .sram_wdata_o(b_wdata), .sram_rdata_i(b_rdata),
    .sram_n_we_o(b_n_we), .sram_n_oe_o(b_n_oe)
  );

  // Behavioural srams
  logic [7:0]  mem_a [4096];
  logic [7:0]  mem_b [4096];
  int          b_wr_cnt = 0;
  logic [11:0] b_wr_addr;
  logic [7:0]  b_wr_data;

  always @(negedge a_n_we) mem_a[a_addr] = a_wdata;
  always @(negedge b_n_we) begin
    mem_b[b_addr] = b_wdata;
    b_wr_cnt  = b_wr_cnt + 1;
    b_wr_addr = b_addr;
    b_wr_data = b_wdata;
  end
  assign a_rdata = a_n_oe ? 8'hEE : mem_a[a_addr];
  assign b_rdata = b_n_oe ? 8'hEE : mem_b[b_addr];

  // Per-cycle monitors: strobe exclusivity, address/data stability while busy, pulse counts
  int          viol = 0, stab_err = 0, a_rsp_cnt = 0, b_rsp_cnt = 0;
  int          we_run = 0, oe_run = 0, we_last = 0, oe_last = 0;
  logic        a_busy_p = 1'b0, b_busy_p = 1'b0;
  logic [11:0] a_addr_p, b_addr_p;
  logic [7:0]  a_wd_p, b_wd_p;

  always @(negedge clk) begin
    if ((!a_n_we && !a_n_oe) || (!b_n_we && !b_n_oe)) viol <= viol + 1;
    if (!a_ready && a_busy_p && (a_addr !== a_addr_p || a_wdata !== a_wd_p)) stab_err <= stab_err + 1;
    if (!b_ready && b_busy_p && (b_addr !== b_addr_p || b_wdata !== b_wd_p)) stab_err <= stab_err + 1;
    a_busy_p <= !a_ready; a_addr_p <= a_addr; a_wd_p <= a_wdata;
    b_busy_p <= !b_ready; b_addr_p <= b_addr; b_wd_p <= b_wdata;
    if (a_rsp_valid) a_rsp_cnt <= a_rsp_cnt + 1;
    if (b_rsp_valid) b_rsp_cnt <= b_rsp_cnt + 1;
    if (!b_n_we) we_run <= we_run + 1;
    else if (we_run != 0) begin we_last <= we_run; we_run <= 0; end
    if (!b_n_oe) oe_run <= oe_run + 1;
    else if (oe_run != 0) begin oe_last <= oe_run; oe_run <= 0; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_of(input int d);
    return (d != 0) ? b_ready : a_ready;
  endfunction

  function automatic logic rsp_of(input int d);
    return (d != 0) ? b_rsp_valid : a_rsp_valid;
  endfunction

  task automatic set_valid(input int d, input logic v);
    if (d != 0) b_valid = v;
    else        a_valid = v;
  endtask

  // Called at a negedge with the request already driven; returns after the accept edge + #1.
  task automatic wait_accept(input int d);
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (ready_of(d)) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int d, input logic we, input logic [11:0] addr, input logic [7:0] wd,
                    output int lat, output logic [7:0] rd);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd;
    set_valid(d, 1'b1);
    wait_accept(d);
    set_valid(d, 1'b0);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (rsp_of(d)) begin lat = k; break; end
    end
    if (lat == 0) check("rsp_timeout", 0, 1);
    rd = (d != 0) ? b_rsp_rdata : a_rsp_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, t0, t1, cnt0, wr0;
    logic [7:0] rd;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", a_ready, 1);
    check("rst_n_we", a_n_we, 1);
    check("rst_n_oe", a_n_oe, 1);
    check("rst_addr", a_addr, 0);
    check("rst_wdata", a_wdata, 0);
    check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_rdata", a_rsp_rdata, 0);
    rst = 1'b0;

    // 1: write then read, default timing
    op(0, 1'b1, 12'h123, 8'hA5, lat, rd);
    check("t1_wr_lat", lat, 3);
    check("t1_mem", mem_a[12'h123], 8'hA5);
    op(0, 1'b0, 12'h123, 8'h00, lat, rd);
    check("t1_rd_lat", lat, 2);
    check("t1_rdata", rd, 8'hA5);

    // 2: back-to-back writes with valid held, bottom and top address
    @(negedge clk);
    req_we = 1'b1; req_addr = 12'h000; req_wdata = 8'h11; a_valid = 1'b1;
    wait_accept(0);
    t0 = cyc;
    req_addr = 12'hFFF; req_wdata = 8'h22;
    @(negedge clk);
    wait_accept(0);
    t1 = cyc;
    a_valid = 1'b0;
    check("t2_accept_gap", t1 - t0, 4);
    repeat (6) @(negedge clk);
    check("t2_mem_lo", mem_a[12'h000], 8'h11);
    check("t2_mem_hi", mem_a[12'hFFF], 8'h22);
    check("t2_rdata_held", a_rsp_rdata, 8'hA5);
    op(0, 1'b0, 12'h000, 8'h00, lat, rd);
    check("t2_rd_lo", rd, 8'h11);
    op(0, 1'b0, 12'hFFF, 8'h00, lat, rd);
    check("t2_rd_hi", rd, 8'h22);

    // 3: stretched strobes on the second instance
    op(1, 1'b1, 12'h055, 8'h5A, lat, rd);
    check("t3_wr_lat", lat, 5);
    check("t3_we_low", we_last, 3);
    op(1, 1'b0, 12'h055, 8'h00, lat, rd);
    check("t3_rd_lat", lat, 3);
    check("t3_oe_low", oe_last, 2);
    check("t3_rdata", rd, 8'h5A);

    // 5: reset pulse during WRITE
    @(negedge clk);
    req_we = 1'b1; req_addr = 12'h010; req_wdata = 8'h3C; a_valid = 1'b1;
    wait_accept(0);
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t5_in_write", a_n_we, 0);
    cnt0 = a_rsp_cnt;
    #2 rst = 1'b1;
    #1;
    check("t5_n_we_async", a_n_we, 1);
    check("t5_n_oe_async", a_n_oe, 1);
    check("t5_ready_async", a_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_rsp", a_rsp_cnt - cnt0, 0);
    check("t5_ready", a_ready, 1);
    op(0, 1'b0, 12'h010, 8'h00, lat, rd);
    check("t5_rdata", rd, 8'h3C);

    // 6: toggling requests while busy are ignored
    cnt0 = b_rsp_cnt;
    wr0  = b_wr_cnt;
    @(negedge clk);
    req_we = 1'b1; req_addr = 12'h200; req_wdata = 8'h77; b_valid = 1'b1;
    wait_accept(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_addr_hold", b_addr, 12'h200);
      b_valid   = ((i % 2) == 0);
      req_we    = ((i % 2) == 1);
      req_addr  = 12'h300 + 12'(i);
      req_wdata = 8'h90 + 8'(i);
    end
    b_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_one_write", b_wr_cnt - wr0, 1);
    check("t6_wr_addr", b_wr_addr, 12'h200);
    check("t6_wr_data", b_wr_data, 8'h77);
    check("t6_one_rsp", b_rsp_cnt - cnt0, 1);
    op(1, 1'b0, 12'h200, 8'h00, lat, rd);
    check("t6_rdata", rd, 8'h77);

    // 4: invariants over the whole run
    check("t4_strobe_excl", viol, 0);
    check("t4_addr_stable", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
